// File: rtl/line_fill_pkg.sv
// Shared types and default geometry for the line fill backing memory.
package line_fill_pkg;

  localparam int DEF_WORD_W         = 32;
  localparam int DEF_WORDS_PER_LINE = 4;
  localparam int DEF_DEPTH_WORDS    = 4096;

  localparam int OFF_W  = $clog2(DEF_WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(DEF_DEPTH_WORDS);
  localparam int LINE_W = DEF_WORD_W * DEF_WORDS_PER_LINE;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST,
    WRITE
  } state_t;

endpackage

// File: rtl/line_fill_memory_mem_array.sv
// Single-port synchronous RAM, one-cycle read latency; each word starts out holding its own index.
module mem_array #(
  parameter int WORD_W      = 32,
  parameter int DEPTH_WORDS = 4096,
  localparam int AW         = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  typedef logic [WORD_W-1:0] mem_t [DEPTH_WORDS];

  function automatic mem_t load_contents();
    mem_t m;
    for (int i = 0; i < DEPTH_WORDS; i++) m[i] = WORD_W'(i);
    return m;
  endfunction

  mem_t mem = load_contents();

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/line_fill_memory.sv
// Backing memory behind the cache: fixed-latency line fills, line writebacks, request statistics.
//   state | meaning
//   IDLE  | ready for a request
//   WAIT  | fill latency countdown; read of word 0 issued when count hits 0
//   BURST | streaming fill words, one per cycle
//   WRITE | absorbing writeback words, one per cycle
module line_fill_memory
  import line_fill_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int WORD_W         = DEF_WORD_W,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int LATENCY        = 8,
  parameter int DEPTH_WORDS    = DEF_DEPTH_WORDS
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic [ADDR_W-1:0]                   req_addr,
  input  logic                                req_write,
  input  logic                                req_prefetch,
  input  logic [WORD_W*WORDS_PER_LINE-1:0]    req_wdata,
  output logic                                resp_valid,
  output logic [WORD_W-1:0]                   resp_data,
  output logic [$clog2(WORDS_PER_LINE)-1:0]   resp_idx,
  output logic                                resp_last,
  output logic                                resp_prefetch,
  output logic                                wb_done,
  output logic [31:0]                         stat_reads,
  output logic [31:0]                         stat_prefetches,
  output logic [31:0]                         stat_writebacks
);

  localparam int OFF_B = $clog2(WORDS_PER_LINE);
  localparam int IDX_B = $clog2(DEPTH_WORDS);
  localparam int CNT_B = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [OFF_B-1:0] LAST_IDX = OFF_B'(WORDS_PER_LINE - 1);

  state_t                   state, state_d;
  logic [CNT_B-1:0]         cnt;
  logic [OFF_B-1:0]         wr_idx, rd_off;
  logic [IDX_B-OFF_B-1:0]   line_q;
  logic [WORD_W-1:0]        wbuf [WORDS_PER_LINE];
  logic                     pf_q;
  logic                     accept, mem_we;
  logic [WORD_W-1:0]        mem_rdata;
  logic                     unused_addr;

  assign unused_addr = ^{req_addr[ADDR_W-1:IDX_B], req_addr[OFF_B-1:0]};

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign mem_we    = (state == WRITE) && !rst;
  assign resp_data = resp_valid ? mem_rdata : '0;

  // rd_off doubles as the word offset for writes, so the single RAM port needs no extra mux
  always_comb begin
    state_d = state;
    rd_off  = '0;
    case (state)
      IDLE:    if (accept) state_d = req_write ? WRITE : WAIT;
      WAIT:    if (cnt == '0) state_d = BURST;
      BURST: begin
        rd_off = resp_idx + OFF_B'(1);
        if (resp_last) state_d = IDLE;
      end
      WRITE: begin
        rd_off = wr_idx;
        if (wr_idx == LAST_IDX) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      wr_idx          <= '0;
      line_q          <= '0;
      pf_q            <= 1'b0;
      resp_valid      <= 1'b0;
      resp_idx        <= '0;
      resp_last       <= 1'b0;
      resp_prefetch   <= 1'b0;
      wb_done         <= 1'b0;
      stat_reads      <= '0;
      stat_prefetches <= '0;
      stat_writebacks <= '0;
    end else begin
      state   <= state_d;
      wb_done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          line_q <= req_addr[IDX_B-1:OFF_B];
          pf_q   <= req_prefetch && !req_write;
          cnt    <= CNT_B'(LATENCY - 1);
          wr_idx <= '0;
          for (int k = 0; k < WORDS_PER_LINE; k++) wbuf[k] <= req_wdata[k*WORD_W +: WORD_W];
          if (req_write)         stat_writebacks <= stat_writebacks + 32'd1;
          else if (req_prefetch) stat_prefetches <= stat_prefetches + 32'd1;
          else                   stat_reads      <= stat_reads + 32'd1;
        end
        WAIT: begin
          cnt <= cnt - CNT_B'(1);
          if (cnt == '0) begin
            resp_valid    <= 1'b1;
            resp_idx      <= '0;
            resp_last     <= 1'b0;
            resp_prefetch <= pf_q;
          end
        end
        BURST: begin
          if (resp_last) begin
            resp_valid    <= 1'b0;
            resp_idx      <= '0;
            resp_last     <= 1'b0;
            resp_prefetch <= 1'b0;
          end else begin
            resp_idx  <= resp_idx + OFF_B'(1);
            resp_last <= (resp_idx + OFF_B'(1)) == LAST_IDX;
          end
        end
        WRITE: begin
          wr_idx <= wr_idx + OFF_B'(1);
          if (wr_idx == LAST_IDX) wb_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  mem_array #(
    .WORD_W      (WORD_W),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  ({line_q, rd_off}),
    .wdata (wbuf[wr_idx]),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_line_fill_memory.sv
// Scoreboard bench for line_fill_memory: acceptance-time reference model feeds expected queues, negedge monitor checks.
module tb_line_fill_memory;
  import line_fill_pkg::*;

  localparam int AW    = 16;
  localparam int WW    = 32;
  localparam int WPL   = 4;
  localparam int LAT   = 8;
  localparam int DEPTH = 4096;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [AW-1:0]     req_addr = '0;
  logic              req_write = 1'b0;
  logic              req_prefetch = 1'b0;
  logic [LINE_W-1:0] req_wdata = '0;
  logic              resp_valid;
  logic [WW-1:0]     resp_data;
  logic [OFF_W-1:0]  resp_idx;
  logic              resp_last;
  logic              resp_prefetch;
  logic              wb_done;
  logic [31:0]       stat_reads, stat_prefetches, stat_writebacks;

  always #5 clk = ~clk;

  line_fill_memory #(
    .ADDR_W(AW), .WORD_W(WW), .WORDS_PER_LINE(WPL), .LATENCY(LAT), .DEPTH_WORDS(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_prefetch(req_prefetch), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_idx(resp_idx),
    .resp_last(resp_last), .resp_prefetch(resp_prefetch), .wb_done(wb_done),
    .stat_reads(stat_reads), .stat_prefetches(stat_prefetches), .stat_writebacks(stat_writebacks)
  );

  typedef struct {
    logic [31:0] data;
    int          idx;
    bit          last;
    bit          pf;
    int          cyc;
  } exp_t;

  logic [WW-1:0] ref_mem [DEPTH];
  exp_t          exp_q[$];
  int            wb_q[$];
  int            cyc = 0, n_acc = 0, next_free = 0;
  int            checks = 0, failures = 0;
  logic [31:0]   m_rd = 0, m_pf = 0, m_wb = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: acts on each accepted request, in terms of lines, words and cycles.
  always @(posedge clk) begin
    if (!rst && req_valid && req_ready) begin
      int base;
      n_acc++;
      base = (int'(req_addr) / WPL * WPL) % DEPTH;
      if (req_write) begin
        for (int k = 0; k < WPL; k++) ref_mem[base + k] = WW'(req_wdata >> (k * WW));
        m_wb++;
        wb_q.push_back(cyc + 1 + WPL);
        next_free = cyc + 1 + WPL;
      end else begin
        if (req_prefetch) m_pf++;
        else              m_rd++;
        for (int k = 0; k < WPL; k++)
          exp_q.push_back('{data: ref_mem[base + k], idx: k, last: (k == WPL - 1),
                            pf: req_prefetch, cyc: cyc + 1 + LAT + k});
        next_free = cyc + 1 + LAT + WPL;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    int   wc;
    chk("req_ready", 32'(req_ready), 32'(!rst && cyc >= next_free));
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      chk("resp_missing_at_cycle", 32'(cyc), 32'(e.cyc));
    end
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL resp_unexpected actual=valid idx=%0d data=%0h required=no response (cycle %0d)",
                 resp_idx, resp_data, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("resp_cycle", 32'(cyc), 32'(e.cyc));
        chk("resp_data", resp_data, e.data);
        chk("resp_idx", 32'(resp_idx), 32'(e.idx));
        chk("resp_last", 32'(resp_last), 32'(e.last));
        chk("resp_prefetch", 32'(resp_prefetch), 32'(e.pf));
      end
    end
    if (wb_q.size() > 0 && wb_q[0] < cyc) begin
      wc = wb_q.pop_front();
      chk("wb_done_missing_at_cycle", 32'(cyc), 32'(wc));
    end
    if (wb_done) begin
      if (wb_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL wb_done_unexpected actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        wc = wb_q.pop_front();
        chk("wb_done_cycle", 32'(cyc), 32'(wc));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Leaves req_valid high so a following send() is issued back-to-back.
  task automatic send(input logic [AW-1:0] a, input bit w, input bit pf, input logic [LINE_W-1:0] wd);
    int n0;
    n0 = n_acc;
    req_valid = 1'b1;
    req_addr = a;
    req_write = w;
    req_prefetch = pf;
    req_wdata = wd;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (n_acc != n0) break;
    end
    chk("request_accepted", 32'(n_acc != n0), 32'd1);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && wb_q.size() == 0 && req_ready) begin
        idle = 1'b1;
        break;
      end
      tick(1);
    end
    chk("idle_within_budget", 32'(idle), 32'd1);
  endtask

  task automatic chk_stats();
    chk("stat_reads", stat_reads, m_rd);
    chk("stat_prefetches", stat_prefetches, m_pf);
    chk("stat_writebacks", stat_writebacks, m_wb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = WW'(i);

    tick(3);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_resp_data", resp_data, 32'd0);
    chk("reset_resp_idx", 32'(resp_idx), 32'd0);
    chk("reset_resp_last", 32'(resp_last), 32'd0);
    chk("reset_resp_prefetch", 32'(resp_prefetch), 32'd0);
    chk("reset_wb_done", 32'(wb_done), 32'd0);
    chk_stats();
    rst = 1'b0;
    tick(1);
    chk("ready_after_reset", 32'(req_ready), 32'd1);

    send(16'h0040, 1'b0, 1'b0, '0);
    req_valid = 1'b0;
    wait_idle();
    chk_stats();

    send(16'h0046, 1'b0, 1'b1, '0);
    req_valid = 1'b0;
    wait_idle();
    chk_stats();

    send(16'h0100, 1'b1, 1'b0, {32'hD, 32'hC, 32'hB, 32'hA});
    req_valid = 1'b0;
    wait_idle();
    send(16'h0100, 1'b0, 1'b0, '0);
    req_valid = 1'b0;
    wait_idle();

    send(16'h0080, 1'b0, 1'b0, '0);
    send(16'h00C4, 1'b0, 1'b1, '0);
    req_valid = 1'b0;
    wait_idle();

    send(16'h1004, 1'b0, 1'b0, '0);
    req_valid = 1'b0;
    wait_idle();
    chk_stats();

    // Abort a fill in its third WAIT cycle; nothing from it may surface.
    send(16'h0200, 1'b0, 1'b0, '0);
    req_valid = 1'b0;
    tick(2);
    rst = 1'b1;
    exp_q.delete();
    wb_q.delete();
    m_rd = 0; m_pf = 0; m_wb = 0;
    next_free = 0;
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("ready_after_abort", 32'(req_ready), 32'd1);
    chk_stats();
    tick(LAT + WPL);
    send(16'h0204, 1'b0, 1'b0, '0);
    req_valid = 1'b0;
    wait_idle();
    chk_stats();

    for (int t = 0; t < 40; t++) begin
      send(AW'($urandom_range(0, 16'hFFFF)), ($urandom_range(0, 9) < 3), 1'($urandom_range(0, 1)),
           {$urandom, $urandom, $urandom, $urandom});
      if ($urandom_range(0, 3) != 0) begin
        req_valid = 1'b0;
        tick($urandom_range(0, 3));
      end
    end
    req_valid = 1'b0;
    wait_idle();
    chk_stats();

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
